instr_fetch_decode: RTL

Upstream front end for the multicycle CPU: holds the program counter, fetches one instruction word per instruction from instruction memory, decodes it into a command code plus register and immediate fields, and presents it to the control state machine over a valid/ack handshake. When the control state machine acks, it also selects how the PC advances (sequential, jump, jump-register or taken branch). Only then is the next fetch started.

---
 rtl/instr_fetch_decode.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_decode.sv
// Front end of the multicycle CPU: owns the PC, fetches one word per instruction,
// decodes it and hands the command to the control FSM over a valid/ack handshake.
module instr_fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [3:0]  cmd,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [25:0] target,
    output logic [31:0] pc_plus4,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jr_addr,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_ISSUE  = 2'd2
    } state_t;

    localparam logic [3:0] CMD_ILLEGAL = 4'd15;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_ir;
    logic [3:0]  r_cmd;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [15:0] r_imm;
    logic [25:0] r_target;
    logic [31:0] r_pc_plus4;
    logic        r_illegal;
    logic [3:0]  w_dec_cmd;
    logic [31:0] w_br_offset;
    logic [31:0] w_jr_word;

    // Command decode from opcode and funct of the held instruction word.
    always_comb begin
        w_dec_cmd = CMD_ILLEGAL;
        case (r_ir[31:26])
            6'h23: w_dec_cmd = 4'd0;
            6'h2B: w_dec_cmd = 4'd1;
            6'h02: w_dec_cmd = 4'd2;
            6'h03: w_dec_cmd = 4'd4;
            6'h05: w_dec_cmd = 4'd5;
            6'h0E: w_dec_cmd = 4'd6;
            6'h08: w_dec_cmd = 4'd8;
            6'h00: begin
                case (r_ir[5:0])
                    6'h08:   w_dec_cmd = 4'd3;
                    6'h20:   w_dec_cmd = 4'd7;
                    6'h22:   w_dec_cmd = 4'd9;
                    6'h2A:   w_dec_cmd = 4'd10;
                    default: w_dec_cmd = CMD_ILLEGAL;
                endcase
            end
            default: w_dec_cmd = CMD_ILLEGAL;
        endcase
    end

    assign w_br_offset = {{14{r_imm[15]}}, r_imm, 2'b00};
    assign w_jr_word   = jr_addr & 32'hFFFF_FFFC;

    // Next-state and PC selection; ack/pc_sel only matter while issuing.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready) begin
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_ack) begin
                    w_state_next = ST_FETCH;
                    case (pc_sel)
                        2'b00:   w_pc_next = r_pc_plus4;
                        2'b01:   w_pc_next = {r_pc_plus4[31:28], r_target, 2'b00};
                        2'b10:   w_pc_next = w_jr_word;
                        default: w_pc_next = r_pc_plus4 + w_br_offset;
                    endcase
                end
            end
            default: begin
                w_state_next = ST_FETCH;
                w_pc_next    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= 32'd0;
            r_cmd      <= 4'd0;
            r_rs       <= 5'd0;
            r_rt       <= 5'd0;
            r_rd       <= 5'd0;
            r_imm      <= 16'd0;
            r_target   <= 26'd0;
            r_pc_plus4 <= RESET_PC + 32'd4;
            r_illegal  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == ST_FETCH && imem_ready) begin
                r_ir <= imem_rdata;
            end
            if (r_state == ST_DECODE) begin
                r_cmd      <= w_dec_cmd;
                r_rs       <= r_ir[25:21];
                r_rt       <= r_ir[20:16];
                r_rd       <= r_ir[15:11];
                r_imm      <= r_ir[15:0];
                r_target   <= r_ir[25:0];
                r_pc_plus4 <= r_pc + 32'd4;
                if (w_dec_cmd == CMD_ILLEGAL) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    // Request is gated by reset so it reads low while reset is held.
    assign imem_req  = (r_state == ST_FETCH) && !reset;
    assign imem_addr = r_pc;
    assign cmd_valid = (r_state == ST_ISSUE);
    assign cmd       = r_cmd;
    assign rs        = r_rs;
    assign rt        = r_rt;
    assign rd        = r_rd;
    assign imm       = r_imm;
    assign target    = r_target;
    assign pc_plus4  = r_pc_plus4;
    assign illegal   = r_illegal;

endmodule
